// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
package exc_pkg;

  // Sequencer states, in the order an exception walks through them.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    REDIRECT = 3'd2,
    HANDLER  = 3'd3,
    RETURN   = 3'd4
  } exc_state_e;

  // Cause codes; 0 means no exception.
  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_SOVF    = 3'd1;
  localparam logic [2:0] CAUSE_UOVF    = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_IMEM    = 3'd4;
  localparam logic [2:0] CAUSE_SYSCALL = 3'd5;
  localparam logic [2:0] CAUSE_DMEM    = 3'd6;

  // Flush masks, bit order {MEM/WB, EX/MEM, ID/EX, IF/ID}.
  localparam logic [3:0] MASK_NONE     = 4'b0000;
  localparam logic [3:0] MASK_ID       = 4'b0001;
  localparam logic [3:0] MASK_EXE      = 4'b0011;
  localparam logic [3:0] MASK_MEM      = 4'b0111;
  localparam logic [3:0] MASK_NOSTAGE  = 4'b0001;
  localparam logic [3:0] MASK_REDIRECT = 4'b0001;

endpackage

// File: rtl/exc_src_select.sv
// Age-priority pick of the faulting PC and flush mask: the oldest stage wins.
module exc_src_select
  import exc_pkg::*;
(
  input  logic        i_exc_id,
  input  logic        i_exc_exe,
  input  logic        i_exc_mem,
  input  logic [31:0] i_pc_id,
  input  logic [31:0] i_pc_exe,
  input  logic [31:0] i_pc_mem,
  output logic [31:0] o_epc,
  output logic [3:0]  o_mask
);

  // MEM holds the oldest instruction, then EXE, then ID; no flag means EPC 0.
  always_comb begin
    o_epc  = 32'd0;
    o_mask = MASK_NOSTAGE;
    if (i_exc_mem) begin
      o_epc  = i_pc_mem;
      o_mask = MASK_MEM;
    end else if (i_exc_exe) begin
      o_epc  = i_pc_exe;
      o_mask = MASK_EXE;
    end else if (i_exc_id) begin
      o_epc  = i_pc_id;
      o_mask = MASK_ID;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: latches EPC/CAUSE, flushes the pipeline, redirects
// fetch to the cause handler and back to EPC + RET_OFFSET on return.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter logic [31:0] VECTOR_STRIDE = 32'd16,
  parameter logic [31:0] RET_OFFSET    = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_in,
  input  logic        exception_ID_in,
  input  logic        exception_EXE_in,
  input  logic        exception_MEM_in,
  input  logic [2:0]  cause_in,
  input  logic [31:0] PC_ID_in,
  input  logic [31:0] PC_EXE_in,
  input  logic [31:0] PC_MEM_in,
  input  logic        eret_in,
  output logic [3:0]  flush_out,
  output logic        stall_fetch_out,
  output logic        pc_redirect_out,
  output logic [31:0] pc_target_out,
  output logic [31:0] EPC_out,
  output logic [2:0]  CAUSE_out,
  output logic        in_handler_out,
  output logic        double_fault_out,
  output logic [7:0]  exc_count_out
);

  exc_state_e  r_state;
  exc_state_e  w_next_state;
  logic [31:0] r_epc;
  logic [2:0]  r_cause;
  logic [3:0]  r_mask;
  logic [7:0]  r_count;
  logic        r_double_fault;
  logic [31:0] w_sel_epc;
  logic [3:0]  w_sel_mask;
  logic        w_accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] vector_addr(input logic [2:0] cause);
    return VECTOR_BASE + ({29'd0, cause} * VECTOR_STRIDE);
  endfunction

  exc_src_select u_src_select (
    .i_exc_id  (exception_ID_in),
    .i_exc_exe (exception_EXE_in),
    .i_exc_mem (exception_MEM_in),
    .i_pc_id   (PC_ID_in),
    .i_pc_exe  (PC_EXE_in),
    .i_pc_mem  (PC_MEM_in),
    .o_epc     (w_sel_epc),
    .o_mask    (w_sel_mask)
  );

  assign w_accept = (r_state == IDLE) && exception_in;

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Exception context, acceptance counter and sticky double-fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc          <= 32'd0;
      r_cause        <= CAUSE_NONE;
      r_mask         <= MASK_NONE;
      r_count        <= 8'd0;
      r_double_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_epc   <= w_sel_epc;
        r_cause <= cause_in;
        r_mask  <= w_sel_mask;
        r_count <= sat_inc8(r_count);
      end
      if ((r_state != IDLE) && exception_in) r_double_fault <= 1'b1;
    end
  end

  // Next-state logic and state-decoded outputs (no path from exception_in).
  always_comb begin
    w_next_state    = r_state;
    flush_out       = MASK_NONE;
    stall_fetch_out = 1'b0;
    pc_redirect_out = 1'b0;
    pc_target_out   = 32'd0;
    in_handler_out  = 1'b0;
    case (r_state)
      IDLE: begin
        if (exception_in) w_next_state = FLUSH;
      end
      FLUSH: begin
        flush_out       = r_mask;
        stall_fetch_out = 1'b1;
        w_next_state    = REDIRECT;
      end
      REDIRECT: begin
        pc_redirect_out = 1'b1;
        flush_out       = MASK_REDIRECT;
        pc_target_out   = vector_addr(r_cause);
        w_next_state    = HANDLER;
      end
      HANDLER: begin
        in_handler_out = 1'b1;
        if (eret_in) w_next_state = RETURN;
      end
      RETURN: begin
        pc_redirect_out = 1'b1;
        pc_target_out   = r_epc + RET_OFFSET;
        flush_out       = MASK_REDIRECT;
        in_handler_out  = 1'b1;
        w_next_state    = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign EPC_out          = r_epc;
  assign CAUSE_out        = r_cause;
  assign double_fault_out = r_double_fault;
  assign exc_count_out    = r_count;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer with default parameters.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exception_in, exception_ID_in, exception_EXE_in, exception_MEM_in;
  logic [2:0]  cause_in;
  logic [31:0] PC_ID_in, PC_EXE_in, PC_MEM_in;
  logic        eret_in;
  logic [3:0]  flush_out;
  logic        stall_fetch_out, pc_redirect_out;
  logic [31:0] pc_target_out, EPC_out;
  logic [2:0]  CAUSE_out;
  logic        in_handler_out, double_fault_out;
  logic [7:0]  exc_count_out;

  int errors = 0;
  int checks = 0;

  exception_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .exception_in     (exception_in),
    .exception_ID_in  (exception_ID_in),
    .exception_EXE_in (exception_EXE_in),
    .exception_MEM_in (exception_MEM_in),
    .cause_in         (cause_in),
    .PC_ID_in         (PC_ID_in),
    .PC_EXE_in        (PC_EXE_in),
    .PC_MEM_in        (PC_MEM_in),
    .eret_in          (eret_in),
    .flush_out        (flush_out),
    .stall_fetch_out  (stall_fetch_out),
    .pc_redirect_out  (pc_redirect_out),
    .pc_target_out    (pc_target_out),
    .EPC_out          (EPC_out),
    .CAUSE_out        (CAUSE_out),
    .in_handler_out   (in_handler_out),
    .double_fault_out (double_fault_out),
    .exc_count_out    (exc_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exception_in = 0; exception_ID_in = 0; exception_EXE_in = 0; exception_MEM_in = 0;
    cause_in = 0; eret_in = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flush"}, {28'd0, flush_out}, 32'h0);
    check({tag, ".stall"}, {31'd0, stall_fetch_out}, 32'h0);
    check({tag, ".redir"}, {31'd0, pc_redirect_out}, 32'h0);
    check({tag, ".target"}, pc_target_out, 32'h0);
    check({tag, ".epc"}, EPC_out, 32'h0);
    check({tag, ".cause"}, {29'd0, CAUSE_out}, 32'h0);
    check({tag, ".inh"}, {31'd0, in_handler_out}, 32'h0);
    check({tag, ".df"}, {31'd0, double_fault_out}, 32'h0);
    check({tag, ".cnt"}, {24'd0, exc_count_out}, 32'h0);
  endtask

  initial begin
    clear_inputs();
    PC_ID_in = 32'h40; PC_EXE_in = 32'h1111; PC_MEM_in = 32'h2222;
    reset = 1;
    step(); step();
    check_all_zero("reset");
    reset = 0;

    // Test 1: ID-only exception, cause 3, PC_ID 0x40.
    exception_in = 1; exception_ID_in = 1; cause_in = 3;
    step();
    clear_inputs();
    check("t1.flush", {28'd0, flush_out}, 32'h1);
    check("t1.stall", {31'd0, stall_fetch_out}, 32'h1);
    check("t1.redir_lo", {31'd0, pc_redirect_out}, 32'h0);
    check("t1.epc", EPC_out, 32'h40);
    check("t1.cause", {29'd0, CAUSE_out}, 32'h3);
    check("t1.cnt", {24'd0, exc_count_out}, 32'h1);
    step();
    check("t1.redir", {31'd0, pc_redirect_out}, 32'h1);
    check("t1.target", pc_target_out, 32'h130);
    check("t1.rflush", {28'd0, flush_out}, 32'h1);
    check("t1.rstall", {31'd0, stall_fetch_out}, 32'h0);
    step();
    check("t1.inh", {31'd0, in_handler_out}, 32'h1);
    check("t1.hredir", {31'd0, pc_redirect_out}, 32'h0);
    check("t1.hflush", {28'd0, flush_out}, 32'h0);

    // Test 4: second exception during HANDLER.
    exception_in = 1; exception_MEM_in = 1; cause_in = 5; PC_MEM_in = 32'h99;
    step();
    clear_inputs();
    check("t4.df", {31'd0, double_fault_out}, 32'h1);
    check("t4.epc", EPC_out, 32'h40);
    check("t4.cause", {29'd0, CAUSE_out}, 32'h3);
    check("t4.cnt", {24'd0, exc_count_out}, 32'h1);
    check("t4.inh", {31'd0, in_handler_out}, 32'h1);
    check("t4.flush", {28'd0, flush_out}, 32'h0);

    // Return from the first handler: EPC 0x40 -> 0x41.
    eret_in = 1;
    step();
    clear_inputs();
    check("r1.redir", {31'd0, pc_redirect_out}, 32'h1);
    check("r1.target", pc_target_out, 32'h41);
    check("r1.flush", {28'd0, flush_out}, 32'h1);
    check("r1.inh", {31'd0, in_handler_out}, 32'h1);
    step();
    check("r1.idle_inh", {31'd0, in_handler_out}, 32'h0);
    check("r1.idle_redir", {31'd0, pc_redirect_out}, 32'h0);
    check("r1.epc_hold", EPC_out, 32'h40);

    // eret in IDLE is ignored.
    eret_in = 1;
    step();
    clear_inputs();
    check("idle_eret.redir", {31'd0, pc_redirect_out}, 32'h0);
    check("idle_eret.inh", {31'd0, in_handler_out}, 32'h0);

    // Test 2: all stage flags, MEM oldest wins.
    exception_in = 1; exception_ID_in = 1; exception_EXE_in = 1; exception_MEM_in = 1;
    cause_in = 1; PC_ID_in = 32'h40; PC_EXE_in = 32'h30; PC_MEM_in = 32'h20;
    step();
    clear_inputs();
    check("t2.flush", {28'd0, flush_out}, 32'h7);
    check("t2.epc", EPC_out, 32'h20);
    check("t2.cnt", {24'd0, exc_count_out}, 32'h2);
    step();
    check("t2.target", pc_target_out, 32'h110);
    step();
    check("t2.inh", {31'd0, in_handler_out}, 32'h1);

    // Test 3: eret with EPC 0x20 -> redirect to 0x21, then IDLE.
    eret_in = 1;
    step();
    clear_inputs();
    check("t3.redir", {31'd0, pc_redirect_out}, 32'h1);
    check("t3.target", pc_target_out, 32'h21);
    step();
    check("t3.inh", {31'd0, in_handler_out}, 32'h0);
    check("t3.redir_lo", {31'd0, pc_redirect_out}, 32'h0);

    // EXE over ID.
    exception_in = 1; exception_ID_in = 1; exception_EXE_in = 1; cause_in = 4;
    step();
    clear_inputs();
    check("exe.flush", {28'd0, flush_out}, 32'h3);
    check("exe.epc", EPC_out, 32'h30);
    step();
    check("exe.target", pc_target_out, 32'h140);
    step();
    eret_in = 1; step(); clear_inputs(); step();

    // Exception with no stage flag: EPC 0, mask 0001.
    exception_in = 1; cause_in = 6;
    step();
    clear_inputs();
    check("nostage.flush", {28'd0, flush_out}, 32'h1);
    check("nostage.epc", EPC_out, 32'h0);
    check("nostage.cnt", {24'd0, exc_count_out}, 32'h4);
    step();
    check("nostage.target", pc_target_out, 32'h160);
    step();
    eret_in = 1; step(); clear_inputs(); step();

    // Test 5: reset asserted during REDIRECT.
    exception_in = 1; exception_ID_in = 1; cause_in = 2;
    step();
    clear_inputs();
    step();
    check("t5.pre_redir", {31'd0, pc_redirect_out}, 32'h1);
    reset = 1;
    step();
    check_all_zero("t5");
    reset = 0;
    step();
    check("t5.after_redir", {31'd0, pc_redirect_out}, 32'h0);
    check("t5.after_inh", {31'd0, in_handler_out}, 32'h0);

    // Simultaneous exception and eret in HANDLER: RETURN taken, double fault set.
    exception_in = 1; exception_ID_in = 1; cause_in = 2; PC_ID_in = 32'h50;
    step();
    clear_inputs();
    step();
    check("sim.target_vec", pc_target_out, 32'h120);
    step();
    exception_in = 1; eret_in = 1; PC_ID_in = 32'h77;
    step();
    clear_inputs();
    check("sim.redir", {31'd0, pc_redirect_out}, 32'h1);
    check("sim.target", pc_target_out, 32'h51);
    check("sim.df", {31'd0, double_fault_out}, 32'h1);
    check("sim.epc", EPC_out, 32'h50);
    check("sim.cnt", {24'd0, exc_count_out}, 32'h1);
    step();
    check("sim.idle_inh", {31'd0, in_handler_out}, 32'h0);

    // Test 6: 260 round trips saturate the counter at 255.
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 260; i++) begin
      exception_in = 1; exception_ID_in = 1; cause_in = 1;
      step();
      clear_inputs();
      step(); step();
      eret_in = 1;
      step();
      clear_inputs();
      step();
      if (i == 253) check("t6.cnt254", {24'd0, exc_count_out}, 32'd254);
      if (i == 254) check("t6.cnt255", {24'd0, exc_count_out}, 32'd255);
    end
    check("t6.cnt_sat", {24'd0, exc_count_out}, 32'd255);
    check("t6.df", {31'd0, double_fault_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
